traffic_input_conditioner: RTL

Front-end stage that feeds the traffic light controller. It synchronises and debounces the raw vehicle sensor and the raw pedestrian walk button. It turns each debounced walk-button press into a request that is held until the controller acknowledges it. It also produces a one-cycle timebase tick, so the controller sequences its states on a clean 1 Hz enable instead of a derived clock.

---
 rtl/traffic_pkg.sv | 15 +
 rtl/debounce_sync.sv | 43 ++++
 rtl/traffic_input_conditioner.sv | 65 ++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared defaults and sizing helper for the traffic light front end.
// Simulation-scale and board-scale timing constants live side by side.
package traffic_pkg;

    localparam int SIM_CLK_DIV    = 10;
    localparam int SIM_DEBOUNCE   = 4;
    localparam int BOARD_CLK_DIV  = 100000000;
    localparam int BOARD_DEBOUNCE = 1000000;

    // Bits needed to hold a count of 0..cycles inclusive.
    function automatic int cnt_width(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_sync.sv
// Purpose: 2-flop synchroniser followed by a stable-level debounce filter.
// Latency: DEBOUNCE_CYCLES+2 edges from the first edge sampling a stable level.
// Backpressure: none; free-running level filter.
module debounce_sync
    import traffic_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    localparam int W = cnt_width(DEBOUNCE_CYCLES);
    // The change is accepted on the edge where the count would reach DEBOUNCE_CYCLES.
    localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);

    logic         sync1;
    logic         sync2;
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            dout  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            if (sync2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= sync2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_input_conditioner.sv
// Purpose: clean sensor/walk inputs, sticky walk request, 1-cycle timebase tick.
// Latency: sensor DEBOUNCE_CYCLES+2 edges, walk_request +1 more; tick every CLK_DIV.
// Backpressure: walk_request holds until walk_ack; other outputs free-running.
module traffic_input_conditioner
    import traffic_pkg::*;
#(
    parameter int CLK_DIV         = BOARD_CLK_DIV,
    parameter int DEBOUNCE_CYCLES = BOARD_DEBOUNCE
) (
    input  logic clk,
    input  logic rst,
    input  logic sensor_raw,
    input  logic walk_button_raw,
    input  logic walk_ack,
    output logic sensor,
    output logic walk_request,
    output logic tick
);

    localparam int TW = cnt_width(CLK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

    logic          walk_db;
    logic          walk_db_q;
    logic          press_pulse;
    logic [TW-1:0] tick_cnt;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor_db (
        .clk  (clk),
        .rst  (rst),
        .din  (sensor_raw),
        .dout (sensor)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_walk_db (
        .clk  (clk),
        .rst  (rst),
        .din  (walk_button_raw),
        .dout (walk_db)
    );

    assign press_pulse = walk_db & ~walk_db_q;

    // A press landing on the same edge as an ack re-arms the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            walk_db_q    <= 1'b0;
            walk_request <= 1'b0;
        end else begin
            walk_db_q    <= walk_db;
            walk_request <= press_pulse | (walk_request & ~walk_ack);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            tick     <= (tick_cnt == TICK_LAST);
        end
    end

endmodule
